// File: rtl/alu_scan_display_if.sv
// rtl/alu_scan_display_if.sv - operand/result inputs and 7-segment outputs of the scan display
//
// Purpose : bundles the ALU-facing inputs and the display-facing outputs
//           so they can be passed as one port.
// Signals : A      [3:0] operand A (shown on digit 3)
//           B      [3:0] operand B (shown on digit 2)
//           Result [7:0] ALU result (digits 1 and 0)
//           an     [3:0] digit enables, active-low
//           seg    [6:0] segments {g,f,e,d,c,b,a}, active-low
//           dp           decimal point, active-low
// Modports: master drives A/B/Result and observes the display,
//           slave is the display controller.
interface alu_scan_display_if;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] Result;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (output A, output B, output Result,
                   input  an, input  seg, input  dp);
   modport slave  (input  A, input  B, input  Result,
                   output an, output seg, output dp);
endinterface

// File: rtl/alu_scan_display.sv
// rtl/alu_scan_display.sv - time-multiplexed 4-digit hex display of A, B and an 8-bit ALU result
//
// Purpose : scans four active-low 7-segment digits, DIV clock cycles per
//           digit. Digit 3 = A, digit 2 = B (decimal point lit),
//           digit 1 = Result[7:4], digit 0 = Result[3:0]. Inputs are
//           captured into shadow registers only when the scan wraps so a
//           whole scan always shows one consistent snapshot.
// Params  : DIV  clock cycles each digit is driven (2 .. 2^20)
// Ports   : clk   system clock, rising edge
//           btnC  asynchronous active-high reset
//           bus   alu_scan_display_if.slave (A, B, Result in; an, seg, dp out)
// Config  : LEADING_ZERO_BLANK_EN - when defined, digit 1 is blanked while
//           the captured Result[7:4] is zero. Timing and capture unchanged.
module alu_scan_display #(
   parameter int DIV = 100000
) (
   input  logic                clk,
   input  logic                btnC,
   alu_scan_display_if.slave   bus
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [3:0]    r_sh_a;
   logic [3:0]    r_sh_b;
   logic [7:0]    r_sh_res;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic          w_tick;
   logic [3:0]    w_nib;
   logic          w_blank;
   logic [3:0]    w_an_nxt;
   logic [6:0]    w_seg_nxt;
   logic          w_dp_nxt;

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   assign w_tick = (r_presc == PW'(DIV - 1));

   // Scan timing and shadow capture. Capture happens on the same tick that
   // wraps the index 3->0, so digit 0 of the new scan already sees it.
   always_ff @(posedge clk or posedge btnC) begin
      if (btnC) begin
         r_presc  <= '0;
         r_idx    <= 2'd0;
         r_sh_a   <= 4'h0;
         r_sh_b   <= 4'h0;
         r_sh_res <= 8'h00;
      end else begin
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
               r_sh_a   <= bus.A;
               r_sh_b   <= bus.B;
               r_sh_res <= bus.Result;
            end
         end else begin
            r_presc <= r_presc + PW'(1);
         end
      end
   end

   // Decode of the current index and shadows; registered below, which gives
   // the one-cycle lag between an index change and the an change.
   always_comb begin
      w_nib     = 4'h0;
      w_blank   = 1'b0;
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'b1111111;
      w_dp_nxt  = 1'b1;

      case (r_idx)
         2'd0:    w_nib = r_sh_res[3:0];
         2'd1:    w_nib = r_sh_res[7:4];
         2'd2:    w_nib = r_sh_b;
         default: w_nib = r_sh_a;
      endcase

`ifdef LEADING_ZERO_BLANK_EN
      w_blank = (r_idx == 2'd1) && (r_sh_res[7:4] == 4'h0);
`else
      w_blank = 1'b0;
`endif

      if (!w_blank) begin
         w_an_nxt          = 4'b1111;
         w_an_nxt[r_idx]   = 1'b0;
         w_seg_nxt         = hex_glyph(w_nib);
         w_dp_nxt          = (r_idx == 2'd2) ? 1'b0 : 1'b1;
      end
   end

   always_ff @(posedge clk or posedge btnC) begin
      if (btnC) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;

endmodule

// File: tb/tb_alu_scan_display.sv
// tb/tb_alu_scan_display.sv - scoreboard bench for alu_scan_display
module tb_alu_scan_display;

   localparam int DIV  = 4;
   localparam int SCAN = 4 * DIV;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk;
   logic btnC;
   alu_scan_display_if bus_if ();

   alu_scan_display #(.DIV(DIV)) dut (
      .clk  (clk),
      .btnC (btnC),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t q[$];

   // Reference model state: edges since reset release and the snapshot the
   // display is currently showing.
   int         m_edge;
   logic [3:0] m_a, m_b;
   logic [7:0] m_res;
   logic [6:0] glyph [16];

   initial begin
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001;
      glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
      glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000;
      glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001;
      glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with inputs already set for the coming edge.
   task automatic cycle();
      exp_t       e;
      int         digit;
      logic [3:0] val;
      m_edge++;
      digit = ((m_edge - 1) / DIV) % 4;
      case (digit)
         0:       val = m_res[3:0];
         1:       val = m_res[7:4];
         2:       val = m_b;
         default: val = m_a;
      endcase
      e.an  = 4'b1111 & ~(4'b0001 << digit);
      e.seg = glyph[val];
      e.dp  = (digit == 2) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (digit == 1 && val == 4'h0) begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
      end
`endif
      q.push_back(e);
      if (m_edge % SCAN == 0) begin
         m_a   = bus_if.A;
         m_b   = bus_if.B;
         m_res = bus_if.Result;
      end
      @(negedge clk);
   endtask

   task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [7:0] r);
      bus_if.A      = a;
      bus_if.B      = b;
      bus_if.Result = r;
   endtask

   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (rnd && ($urandom % 4 == 0)) begin
            bus_if.A      = 4'($urandom);
            bus_if.B      = 4'($urandom);
            bus_if.Result = 8'($urandom);
            if ($urandom % 3 == 0) bus_if.Result[7:4] = 4'h0;
         end
         cycle();
      end
   endtask

   // Asynchronous reset between clock edges, checked before any edge.
   task automatic do_reset();
      #2;
      btnC = 1'b1;
      #1;
      check("rst_an",  bus_if.an,  4'b1111);
      check("rst_seg", bus_if.seg, 7'b1111111);
      check("rst_dp",  bus_if.dp,  1'b1);
      check("rst_q_empty", q.size(), 0);
      @(negedge clk);
      @(negedge clk);
      check("rst_hold_an", bus_if.an, 4'b1111);
      btnC   = 1'b0;
      m_edge = 0;
      m_a    = 4'h0;
      m_b    = 4'h0;
      m_res  = 8'h00;
   endtask

   // Monitor: compares every post-edge output against the next expectation.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("an",  bus_if.an,  e.an);
         check("seg", bus_if.seg, e.seg);
         check("dp",  bus_if.dp,  e.dp);
         check("an_at_most_one_low", ($countones(~bus_if.an) <= 1) ? 1 : 0, 1);
      end
   end

   initial begin
      btnC   = 1'b1;
      m_edge = 0;
      m_a    = 4'h0;
      m_b    = 4'h0;
      m_res  = 8'h00;
      set_in(4'h0, 4'h0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("init_an",  bus_if.an,  4'b1111);
      check("init_seg", bus_if.seg, 7'b1111111);
      btnC = 1'b0;

      // First scan shows zeros, second scan shows 3 / C / 5A.
      set_in(4'h3, 4'hC, 8'h5A);
      run(2 * SCAN, 1'b0);

      // A changes mid digit-1 slot: this scan still shows 3, next shows 8.
      for (int i = 0; i < SCAN; i++) begin
         if (i == DIV + 1) bus_if.A = 4'h8;
         cycle();
      end
      run(SCAN, 1'b0);

      // Leading-zero result.
      set_in(4'h1, 4'h2, 8'h0F);
      run(3 * SCAN, 1'b0);

      // Reset in the middle of the digit-2 slot, then a clean restart.
      run(2 * DIV + 1, 1'b0);
      do_reset();
      set_in(4'hE, 4'hD, 8'hB7);
      run(3 * SCAN, 1'b0);

      // Reset straight after release to cover the shortest run.
      do_reset();
      run(SCAN + 3, 1'b0);
      do_reset();

      // 100 scans of random inputs.
      run(100 * SCAN, 1'b1);

      @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
